// File: rtl/symmetry_job_scheduler.sv
// Round-robin two-port arbiter and sequencer for the shared symmetry core.
// One job in flight: grant, one-cycle load, wait for done or timeout, respond.
module symmetry_job_scheduler #(
   parameter int N       = 8,
   parameter int TIMEOUT = 31
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [1:0]     req_valid,
   input  logic [2*N-1:0] req_data,
   output logic [1:0]     req_ready,
   output logic [1:0]     rsp_valid,
   output logic           rsp_sym,
   output logic           rsp_err,
   input  logic [1:0]     rsp_ready,
   output logic           core_load,
   output logic [N-1:0]   core_data,
   input  logic           core_symmetry,
   input  logic           core_done,
   input  logic           core_busy,
   output logic [7:0]     job_count
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t         state_q, state_d;
   logic           pri_q, gnt_q;
   logic           gnt, gnt_ok;
   logic [N-1:0]   word_q;
   logic [7:0]     timer_q;
   logic           sym_q, err_q;
   logic           hs, tmo, rsp_acc;

   always_comb begin
      gnt    = pri_q;
      gnt_ok = 1'b0;
      if (req_valid[pri_q]) begin
         gnt    = pri_q;
         gnt_ok = 1'b1;
      end else if (req_valid[~pri_q]) begin
         gnt    = ~pri_q;
         gnt_ok = 1'b1;
      end
   end

   assign hs      = (state_q == IDLE) && gnt_ok && !core_busy;
   assign tmo     = (timer_q == 8'(TIMEOUT - 1));
   assign rsp_acc = (state_q == RESP) && rsp_ready[gnt_q];
   assign core_data = word_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (hs) state_d = ISSUE;
         ISSUE: state_d = WAIT;
         WAIT:  if (core_done || tmo) state_d = RESP;
         RESP:  if (rsp_acc) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // req_ready is held low while rst is asserted so all outputs read 0
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      rsp_sym   = 1'b0;
      rsp_err   = 1'b0;
      core_load = 1'b0;
      unique case (state_q)
         IDLE:  if (gnt_ok && !core_busy && !rst) req_ready[gnt] = 1'b1;
         ISSUE: core_load = 1'b1;
         WAIT:  ;
         RESP: begin
            rsp_valid[gnt_q] = 1'b1;
            rsp_sym          = sym_q;
            rsp_err          = err_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pri_q     <= 1'b0;
         gnt_q     <= 1'b0;
         word_q    <= '0;
         timer_q   <= '0;
         sym_q     <= 1'b0;
         err_q     <= 1'b0;
         job_count <= '0;
      end else begin
         if (hs) begin
            word_q <= req_data[(gnt ? N : 0) +: N];
            gnt_q  <= gnt;
         end
         if (state_q == ISSUE) timer_q <= '0;
         if (state_q == WAIT) begin
            if (core_done) begin
               sym_q <= core_symmetry;
               err_q <= 1'b0;
            end else if (tmo) begin
               sym_q <= 1'b0;
               err_q <= 1'b1;
            end else begin
               timer_q <= timer_q + 8'd1;
            end
         end
         if (rsp_acc) begin
            pri_q <= ~gnt_q;
            if (job_count != 8'hFF) job_count <= job_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_symmetry_job_scheduler.sv
// Directed bench for symmetry_job_scheduler with a behavioural core model.
// Inputs change just after the falling edge; outputs are sampled 1ns later.
module tb_symmetry_job_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
   logic [15:0] req_data;
   logic        rsp_sym, rsp_err, core_load, core_symmetry;
   logic        core_done, core_busy;
   logic [7:0]  core_data, job_count;

   int total = 0;
   int bad   = 0;

   logic       model_en, stray_done, force_busy;
   int         cnt;
   logic [7:0] cdata;

   symmetry_job_scheduler #(.N(8), .TIMEOUT(31)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_sym(rsp_sym), .rsp_err(rsp_err),
      .rsp_ready(rsp_ready),
      .core_load(core_load), .core_data(core_data),
      .core_symmetry(core_symmetry), .core_done(core_done),
      .core_busy(core_busy), .job_count(job_count)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rev8(input logic [7:0] d);
      for (int i = 0; i < 8; i++) rev8[i] = d[7-i];
   endfunction

   // core: done pulses 3 cycles after the load cycle
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= 0;
         cdata <= '0;
      end else if (core_load && model_en) begin
         cnt   <= 3;
         cdata <= core_data;
      end else if (cnt > 0) begin
         cnt <= cnt - 1;
      end
   end

   assign core_done     = (cnt == 1) || stray_done;
   assign core_symmetry = (cdata == rev8(cdata));
   assign core_busy     = force_busy;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(negedge clk);
      #1;
   endtask

   task automatic wait_rsp(input int budget, output int n);
      n = 0;
      while (rsp_valid == 2'b00 && n < budget) begin
         step;
         n++;
      end
      check("wait_rsp", rsp_valid != 2'b00, 1);
   endtask

   task automatic accept(input logic [1:0] r);
      rsp_ready = r;
      step;
      rsp_ready = 2'b00;
   endtask

   int  n;
   logic seen;

   initial begin
      rst = 1'b1; req_valid = 2'b01; req_data = 16'h0081;
      rsp_ready = 2'b00; model_en = 1'b1; stray_done = 1'b0;
      force_busy = 1'b0;
      step; step;
      check("rst_ready", req_ready, 2'b00);
      check("rst_rspv", rsp_valid, 2'b00);
      check("rst_load", core_load, 0);
      check("rst_data", core_data, 8'h00);
      check("rst_cnt", job_count, 8'd0);
      req_valid = 2'b00; rst = 1'b0; #1;
      check("idle_ready0", req_ready, 2'b00);

      // single job
      req_valid = 2'b01; #1;
      check("sj_ready", req_ready, 2'b01);
      step;
      req_valid = 2'b00;
      check("sj_load", core_load, 1);
      check("sj_data", core_data, 8'h81);
      step;
      check("sj_load_off", core_load, 0);
      wait_rsp(20, n);
      check("sj_lat", n, 3);
      check("sj_rspv", rsp_valid, 2'b01);
      check("sj_sym", rsp_sym, 1);
      check("sj_err", rsp_err, 0);
      accept(2'b01);
      check("sj_rspv_off", rsp_valid, 2'b00);
      check("sj_cnt", job_count, 8'd1);

      // alternation
      rst = 1'b1; step; rst = 1'b0;
      req_valid = 2'b11; req_data = 16'h123C; rsp_ready = 2'b11;
      for (int i = 0; i < 4; i++) begin
         wait_rsp(20, n);
         check("alt_gnt", rsp_valid, (i % 2) ? 2'b10 : 2'b01);
         check("alt_sym", rsp_sym, (i % 2) ? 0 : 1);
         step;
      end
      req_valid = 2'b00; rsp_ready = 2'b00;
      check("alt_cnt", job_count, 8'd4);

      // timeout, then a normal job
      model_en = 1'b0;
      req_valid = 2'b01; req_data = 16'h0055;
      step;
      req_valid = 2'b00;
      check("to_load", core_load, 1);
      wait_rsp(40, n);
      check("to_lat", n, 32);
      check("to_err", rsp_err, 1);
      check("to_sym", rsp_sym, 0);
      accept(2'b01);
      model_en = 1'b1;
      req_valid = 2'b01; req_data = 16'h0081;
      step;
      req_valid = 2'b00;
      wait_rsp(20, n);
      check("to2_rspv", rsp_valid, 2'b01);
      check("to2_sym", rsp_sym, 1);
      check("to2_err", rsp_err, 0);
      accept(2'b01);
      check("to_cnt", job_count, 8'd6);

      // response backpressure with requester 1 waiting
      req_valid = 2'b01; req_data = 16'h1281; #1;
      check("bp_ready0", req_ready, 2'b01);
      step;
      req_valid = 2'b10;
      wait_rsp(20, n);
      for (int i = 0; i < 10; i++) begin
         check("bp_rspv", rsp_valid, 2'b01);
         check("bp_sym", rsp_sym, 1);
         check("bp_ready", req_ready, 2'b00);
         step;
      end
      accept(2'b01);
      check("bp_gnt1", req_ready, 2'b10);
      step;
      req_valid = 2'b00;
      rsp_ready = 2'b10;
      wait_rsp(20, n);
      check("bp_rspv1", rsp_valid, 2'b10);
      check("bp_sym1", rsp_sym, 0);
      step;
      rsp_ready = 2'b00;
      check("bp_cnt", job_count, 8'd8);

      // core busy and stray done
      force_busy = 1'b1;
      req_valid = 2'b01; req_data = 16'h0081; #1;
      check("busy_ready", req_ready, 2'b00);
      step;
      check("busy_load", core_load, 0);
      check("busy_ready2", req_ready, 2'b00);
      req_valid = 2'b00; stray_done = 1'b1;
      step;
      stray_done = 1'b0;
      check("stray_idle", rsp_valid, 2'b00);
      force_busy = 1'b0; req_valid = 2'b01; #1;
      check("unbusy_ready", req_ready, 2'b01);
      step;
      req_valid = 2'b00; stray_done = 1'b1;
      check("stray_load", core_load, 1);
      step;
      stray_done = 1'b0;
      check("stray_iss1", rsp_valid, 2'b00);
      step;
      check("stray_iss2", rsp_valid, 2'b00);
      wait_rsp(20, n);
      check("stray_lat", n, 2);
      check("stray_sym", rsp_sym, 1);
      accept(2'b01);
      check("stray_cnt", job_count, 8'd9);

      // async reset in WAIT
      model_en = 1'b0;
      req_valid = 2'b01;
      step;
      req_valid = 2'b00;
      step; step;
      rst = 1'b1; #1;
      check("ar_rspv", rsp_valid, 2'b00);
      check("ar_ready", req_ready, 2'b00);
      check("ar_load", core_load, 0);
      check("ar_data", core_data, 8'h00);
      check("ar_flags", {rsp_sym, rsp_err}, 2'b00);
      check("ar_cnt", job_count, 8'd0);
      step;
      rst = 1'b0; model_en = 1'b1; seen = 1'b0;
      rsp_ready = 2'b11;
      for (int i = 0; i < 40; i++) begin
         step;
         if (rsp_valid != 2'b00) seen = 1'b1;
      end
      check("ar_stale", seen, 0);
      check("ar_cnt2", job_count, 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/symmetry_job_scheduler.md
# symmetry_job_scheduler

Two-port arbiter and sequencer for the shared 8-bit symmetry detector core. Two requesters submit words through valid/ready handshakes. The block grants one requester at a time in round-robin order, issues a one-cycle load with the word held stable, waits for the core's done (bounded by a timeout), and returns the result on the winner's response channel. It sits between the user-facing request logic and the detector core and is that core's only driver.

## Interface

Parameters:
- `N`, 8: data word width; must match the detector core.
- `TIMEOUT`, 31: WAIT cycles without `core_done` before the job is aborted; legal range 1..255.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  2  per-requester word valid.
- `req_data`  in  2*N  `req_data[N-1:0]` belongs to requester 0; `req_data[2N-1:N]` belongs to requester 1.
- `req_ready`  out  2  per-requester accept; at most one bit high.
- `rsp_valid`  out  2  per-requester result valid; at most one bit high.
- `rsp_sym`  out  1  symmetry result of the presented response.
- `rsp_err`  out  1  1 = job aborted by timeout (`rsp_sym` is then 0).
- `rsp_ready`  in  2  per-requester result accept.
- `core_load`  out  1  one-cycle load pulse to the core.
- `core_data`  out  N  word to the core.
- `core_symmetry`  in  1  core result.
- `core_done`  in  1  core completion pulse.
- `core_busy`  in  1  core busy.
- `job_count`  out  8  completed jobs, including aborted ones; saturates at 255.

## Operation

State machine: IDLE, ISSUE, WAIT, RESP.

IDLE:
- Grant is computed combinationally from `req_valid` and the priority pointer `pri`.
- The requester `pri` wins if valid; otherwise the other requester wins if valid.
- `req_ready[g]` is 1 only for the winner, and only while `core_busy` is 0.
- Handshake occurs when `req_valid[g] & req_ready[g]`. On handshake:
  - latch `req_data` slice g into `word_q`;
  - latch g into `gnt_q`;
  - go to ISSUE.

ISSUE:
- `core_load` = 1 for this single cycle.
- Clear `timer`.
- Go to WAIT.

WAIT:
- If `core_done` = 1: latch `core_symmetry` into `sym_q`, clear `err_q`, go to RESP.
- Else if `timer` == `TIMEOUT`-1: set `sym_q` = 0 and `err_q` = 1, go to RESP.
- Else: increment `timer`.

RESP:
- `rsp_valid[gnt_q]` = 1; `rsp_sym` = `sym_q`; `rsp_err` = `err_q`.
- These values are held until `rsp_ready[gnt_q]` = 1.
- On that accept:
  - `pri` = ~`gnt_q`;
  - `job_count` += 1, saturating at 255;
  - go to IDLE.

Data and control rules:
- `core_data` = `word_q` in all states; it is stable from the ISSUE cycle until the next handshake.
- `core_done` is ignored outside WAIT, including a `core_done` in the ISSUE cycle.
- `rsp_ready` of the non-granted requester is ignored.
- `req_valid` may drop without a handshake; no acceptance occurs in that case.

## Timing

Reset values (asynchronous on `rst` = 1):
- state = IDLE, `pri` = 0, `gnt_q` = 0, `word_q` = 0, `timer` = 0, `sym_q` = 0, `err_q` = 0, `job_count` = 0.
- All outputs are 0. In IDLE, `req_ready` tracks the grant logic immediately after reset release.

Latency:
- Handshake cycle T: `core_load` is high at T+1, and WAIT begins at T+2.
- `core_done` at cycle D: `rsp_valid` is high at D+1.
- Timeout: `rsp_valid` is high `TIMEOUT`+1 cycles after the ISSUE cycle.

Throughput and corner cases:
- Minimum job period: 4 cycles plus core latency (IDLE, ISSUE, ≥1 WAIT, RESP with immediate `rsp_ready`).
- Both requesters valid: `pri` wins. After service, the other requester wins the next arbitration, giving strict alternation under continuous load.
- `rst` asserted mid-job (any state): the job is dropped, no response is produced, and the state returns to IDLE. The core is reset by its own reset.

## Test plan

- **Single job:** reset, then `req_valid`=01, `req_data[7:0]`=0x81, core model returns done 3 cycles after load with symmetry 1 → `core_load` one cycle at T+1 with `core_data`=0x81; `rsp_valid`=01, `rsp_sym`=1, `rsp_err`=0; `job_count`=1.
- **Alternation:** both requesters continuously valid, words 0x3C (req0) and 0x12 (req1), `rsp_ready` held high, 4 jobs → grant order 0,1,0,1; `rsp_sym` 1,0,1,0; `job_count`=4.
- **Timeout:** `TIMEOUT`=31, core never asserts done → `rsp_valid` exactly 32 cycles after the ISSUE cycle, with `rsp_err`=1 and `rsp_sym`=0; the next job then completes normally.
- **Response backpressure:** `rsp_ready` held low for 10 cycles, while requester 1 is valid and requester 0's response is pending → `rsp_valid`/`rsp_sym` held stable, `req_ready`=00 throughout, and requester 1 is granted on the cycle after the accept.
- **Core busy and stray done:** `core_busy`=1 in IDLE gives `req_ready`=00; a `core_done` pulse in IDLE or ISSUE produces no response.
- **Async reset mid-WAIT:** assert `rst` in WAIT → all outputs are 0 immediately; after release, no stale `rsp_valid` appears and `job_count`=0.
